// File: rtl/if_id_stage_pkg.sv
// Shared core definitions for the fetch stage.
// Widths, NOP encoding and fetch-FSM states.
package if_id_stage_pkg;
  localparam int DEF_PC_WIDTH    = 8;
  localparam int DEF_INSTR_WIDTH = 16;

  localparam logic [DEF_INSTR_WIDTH-1:0] NOP = '0;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    STALLED  = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_id_stage_pipe_reg.sv
// Pipeline register with sync reset, sync clear
// and load enable.
module pipe_reg #(
  parameter int              W    = 8,
  parameter logic [W-1:0]    INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)    r_q <= INIT;
    else if (clr) r_q <= INIT;
    else if (en)  r_q <= d;
  end

  assign q = r_q;
endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC, IF/ID register, redirect
// handling and saturating debug counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_write,
  input  logic                   ifid_write,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus1,
  output logic                   ifid_valid,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   flush_count
);
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  w_pc_plus1;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic                 w_stall;
  logic                 w_flush;
  fetch_state_t         r_state;
  fetch_state_t         w_next;

  assign w_pc_plus1 = r_pc + PC_WIDTH'(1);
  assign w_stall    = ~pc_write | ~ifid_write;
  assign w_flush    = branch_taken;

  always_ff @(posedge clk) begin
    if (reset)        r_pc <= '0;
    else if (w_flush) r_pc <= branch_target;
    else if (pc_write) r_pc <= w_pc_plus1;
  end

  // Flush dominates stall; state only records the last edge's event.
  always_comb begin
    w_next = FETCH;
    unique case (r_state)
      FETCH, STALLED, REDIRECT: begin
        if (w_flush)      w_next = REDIRECT;
        else if (w_stall) w_next = STALLED;
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_next == STALLED && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_next == REDIRECT && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  pipe_reg #(
    .W(INSTR_WIDTH), .INIT(INSTR_WIDTH'(NOP))
  ) u_instr (
    .clk(clk), .reset(reset), .clr(w_flush),
    .en(ifid_write), .d(imem_data), .q(ifid_instr)
  );

  pipe_reg #(.W(PC_WIDTH), .INIT('0)) u_pc1 (
    .clk(clk), .reset(reset), .clr(w_flush),
    .en(ifid_write), .d(w_pc_plus1), .q(ifid_pc_plus1)
  );

  pipe_reg #(.W(1), .INIT(1'b0)) u_valid (
    .clk(clk), .reset(reset), .clr(w_flush),
    .en(ifid_write), .d(1'b1), .q(ifid_valid)
  );

  assign imem_addr   = r_pc;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: reference model plus
// directed scenarios with literal checkpoints.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b1;
  logic        ifid_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc_plus1;
  logic        ifid_valid;
  logic [3:0]  stall_count;
  logic [3:0]  flush_count;

  int n_vec = 0;
  int n_err = 0;

  if_id_stage #(.PC_WIDTH(8), .INSTR_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .ifid_write(ifid_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .ifid_instr(ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  assign imem_data = rom(imem_addr);

  // Reference model: state after each edge, from the operating rules.
  bit         m_known = 0;
  logic [7:0] m_pc;
  logic [15:0] m_instr;
  logic [7:0] m_pp1;
  bit         m_valid;
  int         m_stall, m_flush, m_state;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_instr = 0; m_pp1 = 0; m_valid = 0;
      m_stall = 0; m_flush = 0; m_state = 0; m_known = 1;
    end else if (m_known) begin
      if (branch_taken) begin
        m_pc = branch_target; m_instr = 0; m_pp1 = 0; m_valid = 0;
        if (m_flush < 15) m_flush++;
        m_state = 2;
      end else begin
        if (ifid_write) begin
          m_instr = rom(m_pc); m_pp1 = m_pc + 8'd1; m_valid = 1;
        end
        if (pc_write) m_pc = m_pc + 8'd1;
        if (!pc_write || !ifid_write) begin
          if (m_stall < 15) m_stall++;
          m_state = 1;
        end else m_state = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk("pc", int'(imem_addr), int'(m_pc));
      chk("instr", int'(ifid_instr), int'(m_instr));
      chk("pc_plus1", int'(ifid_pc_plus1), int'(m_pp1));
      chk("valid", int'(ifid_valid), int'(m_valid));
      chk("stall_count", int'(stall_count), m_stall);
      chk("flush_count", int'(flush_count), m_flush);
      chk("state", int'(dut.r_state), m_state);
    end
  end

  task automatic cyc(input bit r, input bit pw, input bit iw,
                     input bit br, input logic [7:0] tgt);
    reset = r; pc_write = pw; ifid_write = iw;
    branch_taken = br; branch_target = tgt;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 8'h00);
  endtask

  initial begin
    cyc(1, 1, 1, 0, 8'h00);
    cyc(1, 1, 1, 0, 8'h00);
    chk("lit_rst_valid", int'(ifid_valid), 0);
    chk("lit_rst_addr", int'(imem_addr), 0);
    chk("lit_rst_instr", int'(ifid_instr), 0);

    run(1);
    chk("lit_e1_instr", int'(ifid_instr), 'h1000);
    chk("lit_e1_pp1", int'(ifid_pc_plus1), 1);
    chk("lit_e1_valid", int'(ifid_valid), 1);
    run(1);
    chk("lit_e2_instr", int'(ifid_instr), 'h1001);
    chk("lit_e2_pp1", int'(ifid_pc_plus1), 2);

    run(3);
    chk("lit_pc5", int'(imem_addr), 5);
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    chk("lit_stall_pc", int'(imem_addr), 5);
    chk("lit_stall_instr", int'(ifid_instr), 'h1004);
    chk("lit_stall_cnt", int'(stall_count), 2);
    chk("lit_stall_state", int'(dut.r_state), 1);
    run(1);
    chk("lit_unstall_state", int'(dut.r_state), 0);
    run(1);
    chk("lit_pc7", int'(imem_addr), 7);

    cyc(0, 0, 1, 1, 8'h20);
    chk("lit_br_pc", int'(imem_addr), 'h20);
    chk("lit_br_valid", int'(ifid_valid), 0);
    chk("lit_br_flush", int'(flush_count), 1);
    chk("lit_br_stall", int'(stall_count), 2);
    chk("lit_br_state", int'(dut.r_state), 2);
    run(1);
    chk("lit_tgt_instr", int'(ifid_instr), 'h1020);
    chk("lit_tgt_valid", int'(ifid_valid), 1);

    cyc(0, 1, 1, 1, 8'hFF);
    cyc(0, 0, 0, 0, 8'h00);
    chk("lit_redir_stall_state", int'(dut.r_state), 1);
    run(1);
    chk("lit_wrap_pc", int'(imem_addr), 0);
    chk("lit_wrap_instr", int'(ifid_instr), 'h10FF);
    chk("lit_wrap_pp1", int'(ifid_pc_plus1), 0);

    run(3);
    cyc(0, 1, 0, 0, 8'h00);
    chk("lit_split_pc", int'(imem_addr), 4);
    chk("lit_split_instr", int'(ifid_instr), 'h1002);
    chk("lit_split_pp1", int'(ifid_pc_plus1), 3);
    chk("lit_split_stall", int'(stall_count), 4);

    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 8'h00);
    chk("lit_sat", int'(stall_count), 15);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1, 8'(i));
    chk("lit_flush_sat", int'(flush_count), 15);

    cyc(0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 1, 8'h33);
    chk("lit_mid_rst_pc", int'(imem_addr), 0);
    chk("lit_mid_rst_valid", int'(ifid_valid), 0);
    chk("lit_mid_rst_stall", int'(stall_count), 0);
    chk("lit_mid_rst_flush", int'(flush_count), 0);
    chk("lit_mid_rst_state", int'(dut.r_state), 0);
    run(1);
    chk("lit_post_rst_instr", int'(ifid_instr), 'h1000);
    run(2);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
